// File: rtl/arith_result_serializer.sv
// Buffers flagged arithmetic results in a small FIFO and streams each one out as
// bytes (data LSB first, then a {7'b0, carry} status byte) over valid/ready.
module arith_result_serializer #(
  parameter int Width = 16,
  parameter int Depth = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [Width-1:0]           Arith_OUT,
  input  logic                       Carry_OUT,
  input  logic                       Arith_Flag,
  output logic [7:0]                 Out_Data,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic                       Out_Last,
  output logic                       Full,
  output logic                       Overflow,
  output logic [$clog2(Depth+1)-1:0] Count
);

  localparam int EW = Width + 1;
  localparam int NB = Width / 8 + 1;
  localparam int PW = $clog2(Depth);
  localparam int IW = $clog2(NB);
  localparam int CW = $clog2(Depth + 1);

  typedef enum logic {S_IDLE, S_SEND} state_e;

  state_e         state_q;
  logic [EW-1:0]  mem_q [Depth];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           full_q, overflow_q;
  logic [EW-1:0]  shift_q;
  logic [IW-1:0]  idx_q;
  logic           valid_q, last_q;
  logic           push, pop, xfer, frame_done;
  logic [EW-1:0]  head;

  // Full is the registered occupancy, so a pop in the same cycle never rescues a push.
  assign push       = Arith_Flag && !full_q;
  assign xfer       = valid_q && Out_Ready;
  assign frame_done = xfer && last_q;
  assign pop        = (count_q != '0) && ((state_q == S_IDLE) || frame_done);
  assign head       = mem_q[rd_ptr_q];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // NOTE: FIFO storage carries no reset; pointers and count define which entries are live.
  always_ff @(posedge CLK) begin
    if (!RST && push) mem_q[wr_ptr_q] <= {Carry_OUT, Arith_OUT};
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      shift_q    <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      if (push)                    wr_ptr_q   <= wr_ptr_q + PW'(1);
      if (pop)                     rd_ptr_q   <= rd_ptr_q + PW'(1);
      if (Arith_Flag && full_q)    overflow_q <= 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CW'(Depth));

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_SEND;
            shift_q <= head;
            idx_q   <= '0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        S_SEND: begin
          if (xfer) begin
            if (last_q) begin
              if (pop) begin
                // Next frame starts on the very next cycle with no idle bubble.
                shift_q <= head;
                idx_q   <= '0;
                last_q  <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                shift_q <= '0;
                idx_q   <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
              end
            end else begin
              // After Width/8 shifts only the carry remains, forming the status byte.
              shift_q <= shift_q >> 8;
              idx_q   <= idx_q + IW'(1);
              last_q  <= (idx_q == IW'(NB - 2));
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Out_Data  = shift_q[7:0];
  assign Out_Valid = valid_q;
  assign Out_Last  = last_q;
  assign Full      = full_q;
  assign Overflow  = overflow_q;
  assign Count     = count_q;

endmodule

// File: tb/tb_arith_result_serializer.sv
// Directed bench: stimulus pushes expected bytes into a scoreboard queue and a
// monitor pops and compares every byte that transfers.
module tb_arith_result_serializer;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int NB = W / 8 + 1;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] Arith_OUT;
  logic         Carry_OUT;
  logic         Arith_Flag;
  logic [7:0]   Out_Data;
  logic         Out_Valid;
  logic         Out_Ready;
  logic         Out_Last;
  logic         Full;
  logic         Overflow;
  logic [2:0]   Count;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q [$];

  arith_result_serializer #(.Width(W), .Depth(D)) dut (
    .CLK(CLK), .RST(RST), .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT),
    .Arith_Flag(Arith_Flag), .Out_Data(Out_Data), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Out_Last(Out_Last), .Full(Full),
    .Overflow(Overflow), .Count(Count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Expected frame: data bytes LSB first, then the status byte with Out_Last set.
  task automatic push_exp(input logic [W-1:0] data, input logic carry);
    for (int i = 0; i < NB - 1; i++) exp_q.push_back({1'b0, data[8*i +: 8]});
    exp_q.push_back({1'b1, 7'b0, carry});
  endtask

  task automatic send(input logic [W-1:0] data, input logic carry, input bit kept);
    Arith_OUT  = data;
    Carry_OUT  = carry;
    Arith_Flag = 1'b1;
    if (kept) push_exp(data, carry);
    tick;
    Arith_Flag = 1'b0;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    Arith_Flag = 1'b0;
    tick;
    tick;
    RST = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || Out_Valid) && n < 200) begin
      tick;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: a byte transfers on the next rising edge when valid and ready are both high.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge CLK);
      if (!RST && Out_Valid && Out_Ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got=%h want=none at %0t", {Out_Last, Out_Data}, $time);
        end else begin
          e = exp_q.pop_front();
          check("stream_byte", {23'b0, Out_Last, Out_Data}, {23'b0, e});
        end
      end
    end
  end

  initial begin
    RST = 1'b0; Arith_OUT = '0; Carry_OUT = 1'b0; Arith_Flag = 1'b0; Out_Ready = 1'b0;

    // Single result and reset state
    do_reset;
    check("rst_valid", Out_Valid, 0);
    check("rst_data", Out_Data, 0);
    check("rst_last", Out_Last, 0);
    check("rst_full", Full, 0);
    check("rst_ovf", Overflow, 0);
    check("rst_count", Count, 0);
    Out_Ready = 1'b1;
    send(16'hA55A, 1'b1, 1);
    check("k_count", Count, 1);
    check("k_valid", Out_Valid, 0);
    tick;
    check("k1_valid", Out_Valid, 1);
    check("k1_count", Count, 0);
    check("k1_data", Out_Data, 8'h5A);
    drain("single_drain");

    // Backpressure
    Out_Ready = 1'b0;
    send(16'hA55A, 1'b1, 1);
    tick;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", Out_Valid, 1);
      check("bp_data", Out_Data, 8'h5A);
      check("bp_last", Out_Last, 0);
      tick;
    end
    Out_Ready = 1'b1;
    drain("bp_drain");

    // Overflow: results 2..5 fill the FIFO, 6 is dropped
    do_reset;
    Out_Ready = 1'b0;
    for (int v = 1; v <= 5; v++) send(W'(v), 1'b0, 1);
    check("ov_full5", Full, 1);
    check("ov_count5", Count, 4);
    check("ov_ovf5", Overflow, 0);
    send(16'd6, 1'b0, 0);
    check("ov_full6", Full, 1);
    check("ov_count6", Count, 4);
    check("ov_ovf6", Overflow, 1);
    Out_Ready = 1'b1;
    drain("ov_drain");
    check("ov_sticky", Overflow, 1);
    check("ov_count_end", Count, 0);
    check("ov_full_end", Full, 0);

    // Back-to-back frames with no valid gap
    do_reset;
    Out_Ready = 1'b1;
    send(16'h0001, 1'b0, 1);
    send(16'h0002, 1'b0, 1);
    send(16'h0003, 1'b0, 1);
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid", Out_Valid, 1);
      tick;
    end
    check("b2b_idle", Out_Valid, 0);
    check("b2b_left", exp_q.size(), 0);

    // Push at full while the status byte pops
    do_reset;
    Out_Ready = 1'b0;
    for (int v = 10; v <= 14; v++) send(W'(v), 1'b0, 1);
    check("pf_full", Full, 1);
    Out_Ready = 1'b1;
    tick;
    tick;
    check("pf_last", Out_Last, 1);
    send(16'h0099, 1'b0, 0);
    check("pf_count", Count, D - 1);
    check("pf_full_after", Full, 0);
    check("pf_ovf", Overflow, 1);
    check("pf_next", Out_Data, 8'h0B);
    drain("pf_drain");

    // Reset mid-frame (Overflow still set from the previous case)
    Out_Ready = 1'b0;
    send(16'h0021, 1'b0, 1);
    send(16'h0022, 1'b0, 1);
    send(16'h0023, 1'b0, 1);
    check("mf_count", Count, 2);
    Out_Ready = 1'b1;
    tick;
    Out_Ready = 1'b0;
    RST = 1'b1;
    Arith_Flag = 1'b1;
    Arith_OUT = 16'hDEAD;
    tick;
    RST = 1'b0;
    Arith_Flag = 1'b0;
    exp_q.delete();
    check("mf_valid", Out_Valid, 0);
    check("mf_count0", Count, 0);
    check("mf_full", Full, 0);
    check("mf_ovf", Overflow, 0);
    Out_Ready = 1'b1;
    send(16'h1234, 1'b0, 1);
    drain("mf_fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
